util_adc_diff_multi: RTL and testbench
======================================

Name: util_adc_diff_multi

Overview:
Multi-channel successor to the single-channel ADC differential detector. For each channel it converts a stream of signed ADC samples into a registered 2-bit bus-state code (positive, negative or idle).
- Adds a hysteresis band around the upper and lower thresholds.
- Adds a per-channel enable.
- Adds a per-channel timeout that holds the last driven state through zero crossings, up to NO_DIFF_WAIT deadband samples.
- Sits between the ADC capture interface and the 1553 decoder; one lane per bus (A/B) or per redundant ADC.

Parameters:
- CHANNELS, 2: number of independent sample lanes.
- BYTE_WIDTH, 1: bytes per sample. SW = BYTE_WIDTH*8 bits, two's-complement signed.
- UP_THRESH, 64: signed positive-entry threshold (sample >= UP_THRESH).
- LOW_THRESH, -64: signed negative-entry threshold (sample <= LOW_THRESH).
- HYST, 16: hysteresis magnitude, >= 0. Elaboration error unless (LOW_THRESH + HYST) < (UP_THRESH - HYST).
- NO_DIFF_WAIT, 50: consecutive deadband valid samples tolerated before dropping to idle. 0 = drop on the first deadband sample.

Ports:
- clk  in  1  sample clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  CHANNELS*SW  channel c sample = wr_data[c*SW +: SW].
- wr_valid  in  1  qualifies all lanes of wr_data this cycle.
- wr_enable  in  CHANNELS  per-channel enable.
- diff_out  out  2*CHANNELS  channel c: bit 2c+1 = positive, bit 2c = negative; 00 = idle; 11 never driven.
- diff_active  out  CHANNELS  channel c state != IDLE (registered with diff_out).

Behaviour:
- Reset: all channels to IDLE; diff_out = 0; diff_active = 0; counters = 0. A reset asserted mid-operation takes effect at the next edge and overrides every other input.
- Per-channel FSM states: IDLE (00), POS (10), NEG (01). diff_out and diff_active decode directly from the state register.
- Latency: a valid sample at edge N updates diff_out at edge N (visible in cycle N+1). Pipeline depth is 1, no bubbles.
- wr_valid = 0: state and counter hold.
- wr_enable[c] = 0: channel c forced to IDLE and counter cleared on the next edge, regardless of wr_valid.
- Classification, valid cycles with the channel enabled; s = signed sample. Thresholds are sign-extended or truncated to SW bits at elaboration.
  - IDLE:
    - s >= UP_THRESH -> POS.
    - s <= LOW_THRESH -> NEG.
    - Otherwise stay IDLE.
    - Counter held at 0.
  - POS:
    - s >= UP_THRESH-HYST -> stay POS, counter cleared.
    - s <= LOW_THRESH -> NEG, counter cleared (direct polarity reversal, no idle cycle).
    - Otherwise (deadband) -> counter increments. On the deadband sample that brings the count to NO_DIFF_WAIT, go to IDLE and clear the counter.
  - NEG: mirror image of POS, using LOW_THRESH+HYST for hold and UP_THRESH for reversal.
- Boundary values:
  - s == UP_THRESH from IDLE enters POS.
  - s == UP_THRESH-HYST in POS holds.
  - s == LOW_THRESH enters NEG.
- Counter width: $clog2(NO_DIFF_WAIT+1), minimum 1. The counter saturates by construction; no wrap.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Package util_adc_diff_pkg:
  - State encoding constants: IDLE = 2'b00, POS = 2'b10, NEG = 2'b01. The diff code equals the state encoding.
  - Function computing the counter width from NO_DIFF_WAIT.
- Sub-module util_adc_diff_chan: one lane (FSM, counter, comparators). Instantiated CHANNELS times in a generate loop; the top level only slices buses and does the parameter check.

Test Plan (CHANNELS=2, BYTE_WIDTH=1, UP=64, LOW=-64, HYST=16, NO_DIFF_WAIT=4):
1. Reset: rst high 4 cycles with wr_valid=1, wr_data=0x7F7F -> diff_out=0000, diff_active=00 throughout. After release with wr_enable=11, diff_out=1010 one edge later.
2. Hysteresis: ch0 samples 64, 48, 47 -> POS, POS, then deadband (diff_out still 10, count=1). Sample 63 from IDLE -> stays 00.
3. Timeout: ch0 in POS, then five samples of 0 -> diff_out bits[1:0]=10 for 3 deadband samples; on the 4th drops to 00; 5th stays 00. Repeat with wr_valid gaps between samples -> same sample count, timeout not advanced during gaps.
4. Reversal: ch1 samples 100 then -64 -> bits[3:2] go 10 then 01 on consecutive valid edges, never 00 or 11.
5. Enable/independence: ch0 POS, ch1 NEG; drop wr_enable[0] for one cycle -> ch0 = 00 next edge; ch1 unchanged at 01; ch0 re-enters POS on the next sample >= 64 after re-enable.
6. Random: 10k random signed samples with random wr_valid/wr_enable, checked against a behavioural model -> bit-exact diff_out, no 11 code ever.

Source files
------------

// File: rtl/util_adc_diff_pkg.sv
// Shared state encoding and sizing helpers for the multi-channel ADC
// differential detector.
package util_adc_diff_pkg;

  // The diff_out code of a lane is its state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    NEG  = 2'b01,
    POS  = 2'b10
  } diff_state_e;

  // Width of the deadband counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned wait_n);
    int unsigned w;
    w = $clog2(wait_n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/util_adc_diff_chan.sv
// One detector lane: threshold/hysteresis classification with a deadband
// timeout that holds the last polarity through zero crossings.
module util_adc_diff_chan
  import util_adc_diff_pkg::*;
#(
  parameter int unsigned SW           = 8,
  parameter int          UP_THRESH    = 64,
  parameter int          LOW_THRESH   = -64,
  parameter int          HYST         = 16,
  parameter int unsigned NO_DIFF_WAIT = 50
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic          en_i,
  input  logic [SW-1:0] sample_i,
  output logic [1:0]    diff_o,
  output logic          active_o
);

  localparam int unsigned CW = cnt_width(NO_DIFF_WAIT);

  localparam logic signed [SW-1:0] UP_T       = SW'(UP_THRESH);
  localparam logic signed [SW-1:0] LOW_T      = SW'(LOW_THRESH);
  localparam logic signed [SW-1:0] UP_HOLD_T  = SW'(UP_THRESH - HYST);
  localparam logic signed [SW-1:0] LOW_HOLD_T = SW'(LOW_THRESH + HYST);
  localparam logic [CW:0]          LIMIT      = (CW + 1)'(NO_DIFF_WAIT);

  diff_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [CW:0]          cnt_inc_c;
  logic                 timeout_c;
  logic signed [SW-1:0] s_c;

  assign s_c       = $signed(sample_i);
  assign cnt_inc_c = {1'b0, cnt_q} + (CW + 1)'(1);
  assign timeout_c = (cnt_inc_c >= LIMIT);

  // Deadband samples advance the counter; the one reaching the limit drops to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (valid_i) begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (s_c >= UP_T)       state_q <= POS;
          else if (s_c <= LOW_T) state_q <= NEG;
        end
        POS: begin
          if (s_c >= UP_HOLD_T) begin
            cnt_q <= '0;
          end else if (s_c <= LOW_T) begin
            state_q <= NEG;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_c[CW-1:0];
          end
        end
        NEG: begin
          if (s_c <= LOW_HOLD_T) begin
            cnt_q <= '0;
          end else if (s_c >= UP_T) begin
            state_q <= POS;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_c[CW-1:0];
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign diff_o   = state_q;
  assign active_o = (state_q != IDLE);

endmodule

// File: rtl/util_adc_diff_multi.sv
// Multi-channel ADC differential detector: slices the sample bus into
// independent lanes and checks the threshold/hysteresis parameters.
module util_adc_diff_multi
  import util_adc_diff_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned BYTE_WIDTH   = 1,
  parameter int          UP_THRESH    = 64,
  parameter int          LOW_THRESH   = -64,
  parameter int          HYST         = 16,
  parameter int unsigned NO_DIFF_WAIT = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*BYTE_WIDTH*8-1:0] wr_data,
  input  logic                     wr_valid,
  input  logic [CHANNELS-1:0]      wr_enable,
  output logic [2*CHANNELS-1:0]    diff_out,
  output logic [CHANNELS-1:0]      diff_active
);

  localparam int unsigned SW = BYTE_WIDTH * 8;

  // Hold bands must not overlap or a sample could both hold POS and NEG.
  if (HYST < 0 || !((LOW_THRESH + HYST) < (UP_THRESH - HYST))) begin : g_param_err
    $error("util_adc_diff_multi: require HYST >= 0 and LOW_THRESH+HYST < UP_THRESH-HYST");
  end

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
    util_adc_diff_chan #(
      .SW           (SW),
      .UP_THRESH    (UP_THRESH),
      .LOW_THRESH   (LOW_THRESH),
      .HYST         (HYST),
      .NO_DIFF_WAIT (NO_DIFF_WAIT)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (wr_valid),
      .en_i     (wr_enable[c]),
      .sample_i (wr_data[c*SW +: SW]),
      .diff_o   (diff_out[2*c +: 2]),
      .active_o (diff_active[c])
    );
  end

endmodule

// File: tb/tb_util_adc_diff_multi.sv
// Self-checking bench for util_adc_diff_multi: directed scenarios with literal
// expectations plus randomized traffic against a behavioural lane model.
module tb_util_adc_diff_multi;

  localparam int NCH  = 2;
  localparam int UP   = 64;
  localparam int LOW  = -64;
  localparam int HY   = 16;
  localparam int WAIT = 4;

  logic              clk;
  logic              rst;
  logic [NCH*8-1:0]  wr_data;
  logic              wr_valid;
  logic [NCH-1:0]    wr_enable;
  logic [2*NCH-1:0]  diff_out;
  logic [NCH-1:0]    diff_active;

  int checks;
  int errors;

  // Model: +1 = positive, -1 = negative, 0 = idle; dead counts deadband samples.
  int m_pol  [NCH];
  int m_dead [NCH];

  util_adc_diff_multi #(
    .CHANNELS     (NCH),
    .BYTE_WIDTH   (1),
    .UP_THRESH    (UP),
    .LOW_THRESH   (LOW),
    .HYST         (HY),
    .NO_DIFF_WAIT (WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_enable   (wr_enable),
    .diff_out    (diff_out),
    .diff_active (diff_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sample_of(input logic [NCH*8-1:0] d, input int c);
    logic [7:0] b;
    b = d[c*8 +: 8];
    return int'($signed(b));
  endfunction

  task automatic model_step();
    int s;
    for (int c = 0; c < NCH; c++) begin
      if (rst || !wr_enable[c]) begin
        m_pol[c]  = 0;
        m_dead[c] = 0;
      end else if (wr_valid) begin
        s = sample_of(wr_data, c);
        if (m_pol[c] == 0) begin
          m_dead[c] = 0;
          if (s >= UP)       m_pol[c] = 1;
          else if (s <= LOW) m_pol[c] = -1;
        end else if ((m_pol[c] == 1 && s >= UP - HY) || (m_pol[c] == -1 && s <= LOW + HY)) begin
          m_dead[c] = 0;
        end else if ((m_pol[c] == 1 && s <= LOW) || (m_pol[c] == -1 && s >= UP)) begin
          m_pol[c]  = -m_pol[c];
          m_dead[c] = 0;
        end else begin
          m_dead[c] = m_dead[c] + 1;
          if (m_dead[c] >= WAIT) begin
            m_pol[c]  = 0;
            m_dead[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2*NCH-1:0] exp_d;
    logic [NCH-1:0]   exp_a;
    for (int c = 0; c < NCH; c++) begin
      exp_d[2*c +: 2] = (m_pol[c] == 1) ? 2'b10 : (m_pol[c] == -1) ? 2'b01 : 2'b00;
      exp_a[c]        = (m_pol[c] != 0);
    end
    checks++;
    if (diff_out !== exp_d) begin
      errors++;
      $display("FAIL model_diff_out t=%0t got %b want %b", $time, diff_out, exp_d);
    end
    checks++;
    if (diff_active !== exp_a) begin
      errors++;
      $display("FAIL model_diff_active t=%0t got %b want %b", $time, diff_active, exp_a);
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (diff_out[2*c +: 2] === 2'b11) begin
        errors++;
        $display("FAIL code11 ch%0d t=%0t got %b want not 11", c, $time, diff_out[2*c +: 2]);
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check mid-cycle.
  task automatic tick(input logic v, input logic [1:0] en, input int s0, input int s1);
    wr_valid  = v;
    wr_enable = en;
    wr_data   = {8'(s1), 8'(s0)};
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pol[c]  = 0;
      m_dead[c] = 0;
    end
    rst       = 1'b1;
    wr_valid  = 1'b1;
    wr_enable = 2'b11;
    wr_data   = 16'h7F7F;
    @(negedge clk);

    // 1. reset dominates a valid, over-threshold stream
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'b11, 127, 127);
      chk("reset_diff", diff_out, 4'b0000);
      chk("reset_active", {2'b00, diff_active}, 4'b0000);
    end
    rst = 1'b0;
    tick(1'b1, 2'b11, 127, 127);
    chk("post_reset", diff_out, 4'b1010);
    chk("post_reset_active", {2'b00, diff_active}, 4'b0011);

    // 2. hysteresis boundaries
    tick(1'b1, 2'b00, 0, 0);
    chk("disable_clear", diff_out, 4'b0000);
    tick(1'b1, 2'b11, 64, 0);
    chk("enter_pos_64", diff_out, 4'b0010);
    tick(1'b1, 2'b11, 48, 0);
    chk("hold_pos_48", diff_out, 4'b0010);
    tick(1'b1, 2'b11, 47, 0);
    chk("deadband_47", diff_out, 4'b0010);
    tick(1'b1, 2'b10, 0, 0);
    tick(1'b1, 2'b11, 63, 0);
    chk("idle_63", diff_out, 4'b0000);

    // 3. timeout, without and with valid gaps
    tick(1'b1, 2'b11, 64, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 2'b11, 0, 0);
      chk($sformatf("timeout_%0d", i), diff_out, (i < 4) ? 4'b0010 : 4'b0000);
    end
    tick(1'b1, 2'b11, 64, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 2'b11, 0, 0);
      chk($sformatf("gap_hold_%0d", i), diff_out, (i < 5) ? 4'b0010 : 4'b0000);
      tick(1'b1, 2'b11, 0, 0);
      chk($sformatf("gap_timeout_%0d", i), diff_out, (i < 4) ? 4'b0010 : 4'b0000);
    end

    // 4. direct reversal on ch1
    tick(1'b1, 2'b11, 0, 100);
    chk("rev_pos", diff_out, 4'b1000);
    tick(1'b1, 2'b11, 0, -64);
    chk("rev_neg", diff_out, 4'b0100);

    // 5. per-channel enable and independence
    tick(1'b1, 2'b11, 64, -64);
    chk("indep_both", diff_out, 4'b0110);
    tick(1'b1, 2'b10, 64, -50);
    chk("indep_dis0", diff_out, 4'b0100);
    tick(1'b1, 2'b11, 64, -64);
    chk("indep_reen", diff_out, 4'b0110);

    // 6. randomized traffic, biased toward threshold edges
    for (int n = 0; n < 10000; n++) begin
      int s [NCH];
      logic [1:0] en;
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0:       s[c] = $urandom_range(0, 255) - 128;
          1:       s[c] = UP - HY + $urandom_range(0, 17) - 2;
          2:       s[c] = LOW + HY - $urandom_range(0, 17) + 2;
          default: s[c] = $urandom_range(0, 30) - 15;
        endcase
        en[c] = ($urandom_range(0, 19) != 0);
      end
      tick(($urandom_range(0, 3) != 0), en, s[0], s[1]);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
